// File: rtl/sum_display.sv
// sum_display: captures a 5-bit sum, converts it to BCD by double-dabble and
// multiplexes two active-low seven-segment digits. Option: LEADING_ZERO_BLANK_EN.
module sum_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [4:0] sum,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic [4:0]      shift_q, shift_d;
    logic [7:0]      bcd_q, bcd_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      ones_q, ones_d;
    logic [CW-1:0]   ref_q, ref_d;
    logic            slot_q, slot_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic [3:0]      lo_adj;
    logic [2:0]      hi_adj;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        ref_d   = ref_q;
        slot_d  = slot_q;
        an_d    = an_q;
        seg_d   = seg_q;

        lo_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        // Tens never exceeds 3 for a 5-bit input, so its shifted-out MSB is dropped.
        hi_adj = (bcd_q[7:4] >= 4'd5) ? bcd_q[6:4] + 3'd3 : bcd_q[6:4];

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = CONV;
                    busy_d  = 1'b1;
                    shift_d = sum;
                    bcd_d   = 8'd0;
                    cnt_d   = 3'd0;
                end
            end
            CONV: begin
                bcd_d   = {hi_adj, lo_adj, shift_q[4]};
                shift_d = {shift_q[3:0], 1'b0};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    tens_d  = bcd_d[7:4];
                    ones_d  = bcd_d[3:0];
                end
            end
            default: state_d = IDLE;
        endcase

        if (ref_q == REF_MAX) begin
            ref_d  = '0;
            slot_d = ~slot_q;
        end else begin
            ref_d = ref_q + 1'b1;
        end

        if (!slot_q) begin
            an_d  = 4'b1110;
            seg_d = decode(ones_q);
        end else begin
            an_d  = 4'b1101;
            seg_d = decode(tens_q);
`ifdef LEADING_ZERO_BLANK_EN
            if (tens_q == 4'd0) begin
                an_d  = 4'b1111;
                seg_d = 7'b1111111;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            shift_q <= 5'd0;
            bcd_q   <= 8'd0;
            cnt_q   <= 3'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            ref_q   <= '0;
            slot_q  <= 1'b0;
            an_q    <= 4'b1110;
            seg_q   <= 7'b1000000;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            ref_q   <= ref_d;
            slot_q  <= slot_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign busy = busy_q;
    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_sum_display.sv
// Randomized self-checking bench for sum_display against an arithmetic model
// (sum/10, sum%10, slot = edge count / REFRESH_DIV).
module tb_sum_display;

    localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [4:0] sum = 5'd0;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_run = 0;
    int n_fail = 0;

    sum_display #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sum(sum),
        .busy(busy), .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [10:0] slot1_of(input int t);
        if (BLANK && t == 0) return {4'b1111, 7'b1111111};
        return {4'b1101, seg_of(t)};
    endfunction

    // Reference model: busy is a 5-edge countdown, result is plain decimal split.
    int         m_k = 0;
    bit         m_busy = 1'b0;
    int         m_left = 0;
    int         m_val = 0;
    int         m_tens = 0;
    int         m_ones = 0;
    logic [3:0] m_an = 4'b1110;
    logic [6:0] m_seg = 7'b1000000;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_k = 0; m_busy = 0; m_left = 0;
            m_tens = 0; m_ones = 0;
            m_an = 4'b1110; m_seg = 7'b1000000;
        end else begin
            if ((m_k / DIV) % 2 == 0) begin
                m_an = 4'b1110; m_seg = seg_of(m_ones);
            end else begin
                {m_an, m_seg} = slot1_of(m_tens);
            end
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_tens = m_val / 10;
                    m_ones = m_val % 10;
                end
            end else if (enable) begin
                m_busy = 1; m_val = int'(sum); m_left = 5;
            end
            m_k++;
        end
    end

    task automatic test_reset;
        logic [10:0] exp;
        @(negedge clk); sum = 5'd17; enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1; #1;
        n_run++;
        if ({busy, an, seg, dp} !== {1'b0, 4'b1110, 7'b1000000, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_async got %b %b %b %b", busy, an, seg, dp);
        end
        @(negedge clk); sum = 5'd0; reset = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            exp = (((k - 1) / DIV) % 2 == 0) ? {4'b1110, 7'b1000000} : slot1_of(0);
            n_run++;
            if ({busy, an, seg, dp} !== {1'b0, exp, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_release k=%0d got %b %b %b exp %b", k, busy, an, seg, exp);
            end
        end
    endtask

    task automatic test_max;
        int s0 = 0, s1 = 0;
        @(negedge clk); sum = 5'd31; enable = 1'b1;
        @(negedge clk); enable = 1'b0; sum = 5'($urandom);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            n_run++;
            if (busy !== (k < 5)) begin
                n_fail++;
                $display("FAIL max_busy k=%0d got %b exp %b", k, busy, k < 5);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            if (an == 4'b1110) s0++;
            if (an == 4'b1101) s1++;
            n_run++;
            if ({an, seg} !== {m_an, m_seg} ||
                (an == 4'b1110 && seg !== 7'b1111001) ||
                (an == 4'b1101 && seg !== 7'b0110000)) begin
                n_fail++;
                $display("FAIL max_disp got %b %b exp %b %b", an, seg, m_an, m_seg);
            end
        end
        n_run++;
        if (s0 != DIV || s1 != DIV) begin
            n_fail++;
            $display("FAIL max_slots got %0d/%0d exp %0d/%0d", s0, s1, DIV, DIV);
        end
    endtask

    task automatic test_nine;
        @(negedge clk); sum = 5'd9; enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            n_run++;
            if ((an == 4'b1110) ? (seg !== 7'b0010000) : ({an, seg} !== slot1_of(0))) begin
                n_fail++;
                $display("FAIL nine_disp got %b %b", an, seg);
            end
        end
    endtask

    task automatic test_held_enable;
        logic eb;
        @(negedge clk); sum = 5'd12; enable = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 0) sum = 5'd5;
            eb = (k <= 4) || (k >= 6 && k <= 10);
            n_run++;
            if (busy !== eb || {an, seg} !== {m_an, m_seg}) begin
                n_fail++;
                $display("FAIL held_busy k=%0d got %b %b %b exp %b", k, busy, an, seg, eb);
            end
            if (k >= 6) begin
                n_run++;
                if ((an == 4'b1110 && seg !== seg_of(2)) || (an == 4'b1101 && seg !== seg_of(1))) begin
                    n_fail++;
                    $display("FAIL held_first k=%0d got %b %b exp 1/2", k, an, seg);
                end
            end
            if (k == 11) enable = 1'b0;
        end
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            n_run++;
            if ((an == 4'b1110) ? (seg !== seg_of(5)) : ({an, seg} !== slot1_of(0))) begin
                n_fail++;
                $display("FAIL held_second got %b %b exp 0/5", an, seg);
            end
        end
    endtask

    task automatic test_reset_abort;
        @(negedge clk); sum = 5'd15; enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        repeat (6 + 2 * DIV) @(negedge clk);
        n_run++;
        if ({busy, an, seg} !== {m_busy, m_an, m_seg}) begin
            n_fail++;
            $display("FAIL abort_pre got %b %b %b", busy, an, seg);
        end
        sum = 5'd27; enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1; #1;
        n_run++;
        if ({busy, an, seg} !== {1'b0, 4'b1110, 7'b1000000}) begin
            n_fail++;
            $display("FAIL abort_now got %b %b %b", busy, an, seg);
        end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            n_run++;
            if ({busy, an, seg} !== {m_busy, m_an, m_seg} ||
                (an == 4'b1110 && seg !== seg_of(0))) begin
                n_fail++;
                $display("FAIL abort_after got %b %b %b", busy, an, seg);
            end
        end
    endtask

    task automatic test_sweep;
        for (int v = 0; v < 32; v++) begin
            @(negedge clk); sum = 5'(v); enable = 1'b1;
            @(negedge clk); enable = 1'b0; sum = 5'($urandom);
            repeat (6) @(negedge clk);
            for (int i = 0; i < 2 * DIV; i++) begin
                @(negedge clk);
                n_run++;
                if ((an == 4'b1110) ? (seg !== seg_of(v % 10)) : ({an, seg} !== slot1_of(v / 10))) begin
                    n_fail++;
                    $display("FAIL sweep v=%0d got %b %b", v, an, seg);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n_run++;
            if ({busy, an, seg, dp} !== {m_busy, m_an, m_seg, 1'b1}) begin
                n_fail++;
                $display("FAIL random i=%0d got %b %b %b %b exp %b %b %b",
                         i, busy, an, seg, dp, m_busy, m_an, m_seg);
            end
            enable = ($urandom_range(0, 9) < 3);
            sum = 5'($urandom);
        end
        enable = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_max();
        test_nine();
        test_held_enable();
        test_reset_abort();
        test_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
